// File: rtl/shake128_squeeze.sv
// SHAKE128 squeeze stage: streams XOF output bytes from a finalized Keccak state,
// requesting a Keccak-f[1600] permutation from the shared core whenever the rate is used up.
module shake128_squeeze #(
    parameter int RATE  = 168,
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1599:0]    state_s_in,
    input  logic [31:0]      state_pos_in,
    input  logic [LEN_W-1:0] outlen,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             perm_start,
    output logic [1599:0]    perm_s_out,
    input  logic [1599:0]    perm_s_in,
    input  logic             perm_done,
    output logic [1599:0]    state_s_out,
    output logic [31:0]      state_pos_out,
    output logic             busy,
    output logic             done
);
    localparam logic [7:0] RATE_B = 8'(RATE);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PERM_REQ,
        PERM_WAIT,
        EMIT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [1599:0]    s_q, s_d;
    logic [7:0]       pos_q, pos_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [1599:0]    s_out_q, s_out_d;
    logic [7:0]       pos_out_q, pos_out_d;

    logic [7:0]       pos_clamped;
    logic [10:0]      bit_idx;
    logic [7:0]       cur_byte;

    assign pos_clamped = (state_pos_in > 32'(RATE)) ? RATE_B : state_pos_in[7:0];
    assign bit_idx     = {pos_q, 3'b000};
    assign cur_byte    = s_q[bit_idx +: 8];

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        s_out_d   = s_out_q;
        pos_out_d = pos_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d     = state_s_in;
                    pos_d   = pos_clamped;
                    rem_d   = outlen;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else if (pos_q == RATE_B) begin
                    state_d = PERM_REQ;
                end else begin
                    state_d = EMIT;
                end
            end
            PERM_REQ: state_d = PERM_WAIT;
            PERM_WAIT: begin
                if (perm_done) begin
                    s_d     = perm_s_in;
                    pos_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pos_d = pos_q + 8'd1;
                    rem_d = rem_q - LEN_W'(1);
                    // No trailing permutation: finishing exactly at the rate boundary leaves pos==RATE.
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end else if (pos_q + 8'd1 == RATE_B) begin
                        state_d = PERM_REQ;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result snapshot is taken on the edge entering DONE and held until the next one.
        if (state_d == DONE && state_q != DONE) begin
            s_out_d   = s_d;
            pos_out_d = pos_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            s_q       <= '0;
            pos_q     <= '0;
            rem_q     <= '0;
            s_out_q   <= '0;
            pos_out_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            pos_q     <= pos_d;
            rem_q     <= rem_d;
            s_out_q   <= s_out_d;
            pos_out_q <= pos_out_d;
        end
    end

    assign out_valid     = (state_q == EMIT);
    assign out_byte      = out_valid ? cur_byte : 8'h00;
    assign perm_start    = (state_q == PERM_REQ);
    assign perm_s_out    = s_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign state_s_out   = s_out_q;
    assign state_pos_out = {24'd0, pos_out_q};

endmodule

// File: tb/tb_shake128_squeeze.sv
// Testbench for shake128_squeeze: directed and randomized squeezes checked against a
// byte-level reference model, with a fixed-latency permutation core (s XOR pattern).
module tb_shake128_squeeze;
    localparam int RATE     = 168;
    localparam int LEN_W    = 16;
    localparam int PERM_LAT = 24;

    logic             clock;
    logic             reset;
    logic             start;
    logic [1599:0]    state_s_in;
    logic [31:0]      state_pos_in;
    logic [LEN_W-1:0] outlen;
    logic [7:0]       out_byte;
    logic             out_valid;
    logic             out_ready;
    logic             perm_start;
    logic [1599:0]    perm_s_out;
    logic [1599:0]    perm_s_in;
    logic             perm_done;
    logic [1599:0]    state_s_out;
    logic [31:0]      state_pos_out;
    logic             busy;
    logic             done;

    logic             resp_done;
    logic             spur_done;
    logic [1599:0]    perm_pat;

    int checks   = 0;
    int failures = 0;
    int perm_cnt = 0;
    int vlat, pslat, dlat, dcount, nperm;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];

    assign perm_done = resp_done | spur_done;

    shake128_squeeze #(.RATE(RATE), .LEN_W(LEN_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .state_s_in    (state_s_in),
        .state_pos_in  (state_pos_in),
        .outlen        (outlen),
        .out_byte      (out_byte),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .perm_start    (perm_start),
        .perm_s_out    (perm_s_out),
        .perm_s_in     (perm_s_in),
        .perm_done     (perm_done),
        .state_s_out   (state_s_out),
        .state_pos_out (state_pos_out),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Permutation core model: fixed latency, result = input XOR perm_pat.
    initial begin : responder
        logic [1599:0] cap;
        resp_done = 1'b0;
        perm_s_in = '0;
        forever begin
            @(negedge clock);
            if (perm_start) begin
                perm_cnt++;
                cap = perm_s_out;
                repeat (PERM_LAT) @(posedge clock);
                #1;
                perm_s_in = cap ^ perm_pat;
                resp_done = 1'b1;
                @(posedge clock);
                #1;
                resp_done = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        int k;
        k = 0;
        for (int i = 199; i >= 0; i--) begin
            if (obs[i*8 +: 8] !== exp[i*8 +: 8]) k = i;
        end
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s first_diff_byte=%0d observed=%h expected=%h",
                   tag, k, obs[k*8 +: 8], exp[k*8 +: 8]);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"}, {out_byte, out_valid, perm_start, busy, done, state_pos_out}, 64'd0);
        chk_state({tag, "_s_out"}, state_s_out, '0);
        chk_state({tag, "_perm_s_out"}, perm_s_out, '0);
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: walk the byte stream; an exhausted rate triggers one permutation before the next byte.
    function automatic void model(input logic [1599:0] st, input int p, input int len,
                                  output logic [1599:0] fs, output int fp, output int np);
        int pos;
        logic [1599:0] s;
        s   = st;
        pos = (p > RATE) ? RATE : p;
        np  = 0;
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            if (pos == RATE) begin
                s   = s ^ perm_pat;
                pos = 0;
                np++;
            end
            exp_q.push_back(s[pos*8 +: 8]);
            pos++;
        end
        fs = s;
        fp = pos;
    endfunction

    // Called at #1 after a posedge with the DUT idle.
    task automatic run_op(input logic [1599:0] st, input int p, input int len,
                          input int rdy_pct, input bit disturb);
        int n;
        int ps0;
        bit fin, stalled, spur_sent;
        logic [7:0] held;
        rx.delete();
        dcount = 0; vlat = -1; pslat = -1; dlat = -1;
        ps0 = perm_cnt;
        state_s_in   = st;
        state_pos_in = 32'(p);
        outlen       = LEN_W'(len);
        out_ready    = 1'b0;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0; fin = 0; stalled = 0; spur_sent = 0; held = 8'h00;
        while (!fin && n < 4000) begin
            if (stalled) chk($sformatf("stall_stable_n%0d", n), {out_valid, out_byte}, {1'b1, held});
            if (out_valid && vlat < 0) vlat = n;
            if (perm_start && pslat < 0) pslat = n;
            if (done) begin
                dcount++;
                dlat = n;
                fin  = 1;
            end else begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                if (out_valid && out_ready) rx.push_back(out_byte);
                stalled = out_valid && !out_ready;
                held    = out_byte;
                if (disturb && n == 20) begin
                    start        = 1'b1;
                    outlen       = LEN_W'(5);
                    state_pos_in = 32'd0;
                end
                if (disturb && !spur_sent && n >= 40 && out_valid) begin
                    spur_done = 1'b1;
                    spur_sent = 1;
                end
                @(posedge clock);
                #1;
                n++;
                start        = 1'b0;
                spur_done    = 1'b0;
                outlen       = LEN_W'(len);
                state_pos_in = 32'(p);
            end
        end
        chk("op_finished_in_budget", 64'(fin), 64'd1);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done) dcount++;
        end
        nperm = perm_cnt - ps0;
    endtask

    task automatic verify(input string name, input logic [1599:0] st, input int p, input int len);
        logic [1599:0] fs;
        int fp, np;
        model(st, p, len, fs, fp, np);
        chk({name, "_count"}, 64'(rx.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < rx.size(); k++)
            chk($sformatf("%s_byte%0d", name, k), 64'(rx[k]), 64'(exp_q[k]));
        chk({name, "_done_once"}, 64'(dcount), 64'd1);
        chk({name, "_perm_starts"}, 64'(nperm), 64'(np));
        chk({name, "_pos_out"}, 64'(state_pos_out), 64'(fp));
        chk_state({name, "_s_out"}, state_s_out, fs);
    endtask

    initial begin : main
        logic [1599:0] st;
        int n, rp, rl, rr;
        reset        = 1'b0;
        start        = 1'b0;
        state_s_in   = '0;
        state_pos_in = '0;
        outlen       = '0;
        out_ready    = 1'b0;
        spur_done    = 1'b0;
        perm_pat     = rand_state();

        repeat (3) @(posedge clock);
        #1;
        chk_zero("reset_idle");
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Plain in-rate squeeze: leaves state_s_out non-zero for the reset check below.
        st = rand_state();
        run_op(st, 50, 3, 100, 0);
        verify("warm", st, 50, 3);
        chk("warm_first_valid", 64'(vlat), 64'd1);
        chk("warm_no_perm", 64'(pslat), -64'sd1);

        // Reset while a permutation is outstanding.
        st           = rand_state();
        state_s_in   = st;
        state_pos_in = 32'd168;
        outlen       = LEN_W'(5);
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        while (!perm_start && n < 10) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("rst_perm_seen", 64'(perm_start), 64'd1);
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clock);
        #1;
        chk_zero("rst_hold");
        reset = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        chk("rst_late_perm_done_ignored", {60'd0, busy, out_valid, done, perm_start}, 64'd0);

        st = rand_state();
        run_op(st, 10, 2, 100, 0);
        verify("pos10", st, 10, 2);

        st = rand_state();
        run_op(st, 168, 3, 100, 0);
        verify("pos168", st, 168, 3);
        chk("pos168_perm_start_lat", 64'(pslat), 64'd1);
        chk("pos168_first_valid", 64'(vlat), 64'(PERM_LAT + 2));

        st = rand_state();
        run_op(st, 166, 4, 100, 0);
        verify("pos166", st, 166, 4);
        chk("pos166_first_valid", 64'(vlat), 64'd1);

        st = rand_state();
        run_op(st, 77, 0, 100, 0);
        verify("len0", st, 77, 0);
        chk("len0_done_lat", 64'(dlat), 64'd1);
        chk("len0_no_valid", 64'(vlat), -64'sd1);
        chk("len0_no_perm", 64'(pslat), -64'sd1);

        st = rand_state();
        run_op(st, 168, 336, 60, 1);
        verify("len336_bp", st, 168, 336);

        st = rand_state();
        run_op(st, 200, 1, 100, 0);
        verify("pos200", st, 200, 1);

        for (int t = 0; t < 3; t++) begin
            st = rand_state();
            rp = $urandom_range(0, 200);
            rl = $urandom_range(0, 300);
            rr = $urandom_range(30, 100);
            run_op(st, rp, rl, rr, 0);
            verify($sformatf("rand%0d", t), st, rp, rl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
